// File: rtl/dp_ram_pkg.sv
// Shared constants and helpers for the dual-port RAM.
// Byte-merge is written once at a wide width and sized by callers.
package dp_ram_pkg;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  localparam int MERGE_MAX_W = 1024;
  localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] i_old,
    input logic [MERGE_MAX_W-1:0] i_new,
    input logic [MERGE_MAX_B-1:0] i_be
  );
    logic [MERGE_MAX_W-1:0] w_res;
    w_res = i_old;
    for (int i = 0; i < MERGE_MAX_B; i++) begin
      if (i_be[i]) begin
        w_res[8*i +: 8] = i_new[8*i +: 8];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/dual_port_ram_read_pipe.sv
// Read-result pipeline: 1 or 2 reset-cleared stages.
// Data registers only load on a valid beat so rdata holds between reads.
module ram_read_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_v0;
  logic [DATA_W-1:0] r_d0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v0 <= 1'b0;
      r_d0 <= '0;
    end else begin
      r_v0 <= i_valid;
      if (i_valid) begin
        r_d0 <= i_data;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_v1;
    logic [DATA_W-1:0] r_d1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_v1 <= 1'b0;
        r_d1 <= '0;
      end else begin
        r_v1 <= r_v0;
        if (r_v0) begin
          r_d1 <= r_d0;
        end
      end
    end

    assign o_valid = r_v1;
    assign o_data  = r_d1;
  end else begin : g_lat1
    assign o_valid = r_v0;
    assign o_data  = r_d0;
  end

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with byte enables and 1/2-cycle read latency.
// On a same-address double write, port A owns every byte it enables.
module dual_port_ram
  import dp_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int RD_LAT  = 1,
  parameter int RW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                coll
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] i_old,
    input logic [DATA_W-1:0] i_new,
    input logic [BE_W-1:0]   i_be
  );
    return DATA_W'(byte_merge(MERGE_MAX_W'(i_old),
                              MERGE_MAX_W'(i_new),
                              MERGE_MAX_B'(i_be)));
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_coll;

  logic              w_a_wr;
  logic              w_b_wr;
  logic              w_same;
  logic              w_ww;
  logic [DATA_W-1:0] w_a_old;
  logic [DATA_W-1:0] w_b_old;
  logic [DATA_W-1:0] w_a_new;
  logic [DATA_W-1:0] w_b_new;
  logic [DATA_W-1:0] w_ab_new;
  logic [DATA_W-1:0] w_a_fin;
  logic [DATA_W-1:0] w_b_fin;
  logic [DATA_W-1:0] w_a_rd;
  logic [DATA_W-1:0] w_b_rd;

  assign w_a_wr  = a_en & a_we;
  assign w_b_wr  = b_en & b_we;
  assign w_same  = (a_addr == b_addr);
  assign w_ww    = w_a_wr & w_b_wr & w_same;

  assign w_a_old = r_mem[a_addr];
  assign w_b_old = r_mem[b_addr];

  assign w_a_new  = f_merge(w_a_old, a_wdata, a_be);
  assign w_b_new  = f_merge(w_b_old, b_wdata, b_be);
  // B bytes first, then A on top: A wins overlapping enables
  assign w_ab_new = f_merge(w_b_new, a_wdata, a_be);

  assign w_a_fin = w_ww ? w_ab_new : w_a_new;
  assign w_b_fin = w_ww ? w_ab_new : w_b_new;

  assign w_a_rd = (w_a_wr && RW_MODE == RW_WRITE_FIRST) ? w_a_fin : w_a_old;
  assign w_b_rd = (w_b_wr && RW_MODE == RW_WRITE_FIRST) ? w_b_fin : w_b_old;

  always_ff @(posedge clk) begin
    if (w_a_wr) begin
      r_mem[a_addr] <= w_a_fin;
    end
    if (w_b_wr && !w_ww) begin
      r_mem[b_addr] <= w_b_fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_ww;
    end
  end

  assign coll = r_coll;

  ram_read_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (a_en),
    .i_data  (w_a_rd),
    .o_valid (a_rvalid),
    .o_data  (a_rdata)
  );

  ram_read_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (b_en),
    .i_data  (w_b_rd),
    .o_valid (b_rvalid),
    .o_data  (b_rdata)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: two instances (LAT1/READ_FIRST, LAT2/WRITE_FIRST)
// share stimulus; a word-level array model predicts both.
module tb_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, a_addr, b_be, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] rd0a, rd0b, rd1a, rd1b;
  logic        v0a, v0b, v1a, v1b, c0, c1;

  always #5 clk = ~clk;

  dual_port_ram #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RW_MODE(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(rd0a), .a_rvalid(v0a),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(rd0b), .b_rvalid(v0b),
    .coll(c0)
  );

  dual_port_ram #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RW_MODE(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(rd1a), .a_rvalid(v1a),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(rd1b), .b_rvalid(v1b),
    .coll(c1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] m_mem [16];
  bit          m_kn  [16];
  logic [31:0] s_d [4][4];
  bit          s_v [4][4];
  bit          s_k [4][4];
  logic [31:0] e_rd [4];
  bit          e_kn [4];
  bit          e_coll;

  typedef struct {
    logic        a_en, a_we;
    logic [3:0]  a_be, a_addr;
    logic [31:0] a_wd;
    logic        b_en, b_we;
    logic [3:0]  b_be, b_addr;
    logic [31:0] b_wd;
    logic        x_av;
    logic [31:0] x_ard;
    logic        x_bv;
    logic [31:0] x_brd;
    logic        x_coll;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [31:0] put_bytes(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] be
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic act_v(input int ch);
    case (ch)
      0: return v0a;
      1: return v0b;
      2: return v1a;
      default: return v1b;
    endcase
  endfunction

  function automatic logic [31:0] act_d(input int ch);
    case (ch)
      0: return rd0a;
      1: return rd0b;
      2: return rd1a;
      default: return rd1b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 4; s++) s_v[c][s] = 1'b0;
      e_rd[c] = '0;
      e_kn[c] = 1'b1;
    end
    e_coll = 1'b0;
  endtask

  // Predicts the effect of the inputs present at the coming edge.
  task automatic model_apply();
    logic [31:0] nm [16];
    bit          nk [16];
    logic        pen, pwe;
    logic [3:0]  pad;
    int          e, ch, slot;
    e_coll = 1'b0;
    if (!rst_n) return;
    e = cyc + 1;
    nm = m_mem;
    nk = m_kn;
    if (b_en && b_we) begin
      nm[b_addr] = put_bytes(nm[b_addr], b_wdata, b_be);
      nk[b_addr] = nk[b_addr] || (b_be == 4'hF);
    end
    if (a_en && a_we) begin
      nm[a_addr] = put_bytes(nm[a_addr], a_wdata, a_be);
      nk[a_addr] = nk[a_addr] || (a_be == 4'hF);
    end
    e_coll = a_en && a_we && b_en && b_we && (a_addr == b_addr);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        pen = p ? b_en : a_en;
        pwe = p ? b_we : a_we;
        pad = p ? b_addr : a_addr;
        if (pen) begin
          ch = d * 2 + p;
          slot = (e + d) % 4;
          s_v[ch][slot] = 1'b1;
          if (pwe && d == 1) begin
            s_d[ch][slot] = nm[pad];
            s_k[ch][slot] = nk[pad];
          end else begin
            s_d[ch][slot] = m_mem[pad];
            s_k[ch][slot] = m_kn[pad];
          end
        end
      end
    end
    m_mem = nm;
    m_kn = nk;
  endtask

  task automatic model_check();
    int slot;
    bit ev;
    slot = cyc % 4;
    for (int ch = 0; ch < 4; ch++) begin
      ev = s_v[ch][slot];
      if (ev) begin
        e_rd[ch] = s_d[ch][slot];
        e_kn[ch] = s_k[ch][slot];
      end
      s_v[ch][slot] = 1'b0;
      chk($sformatf("rvalid ch%0d cyc%0d", ch, cyc),
          {31'b0, act_v(ch)}, {31'b0, ev});
      if (e_kn[ch])
        chk($sformatf("rdata ch%0d cyc%0d", ch, cyc), act_d(ch), e_rd[ch]);
    end
    chk($sformatf("coll0 cyc%0d", cyc), {31'b0, c0}, {31'b0, e_coll});
    chk($sformatf("coll1 cyc%0d", cyc), {31'b0, c1}, {31'b0, e_coll});
  endtask

  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
    cyc++;
    model_check();
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic preload();
    idle();
    for (int i = 0; i < 16; i++) begin
      a_en = 1; a_we = 1; a_be = 4'hF;
      a_addr = 4'(i); a_wdata = i * 32'h01010101;
      step();
    end
    idle();
  endtask

  task automatic do_reset(input int n);
    idle();
    rst_n = 1'b0;
    model_clear();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_kn[i] = 1'b0;
    idle();
    model_clear();
    do_reset(3);

    preload();

    // pending LAT2 read is dropped by a 1-cycle reset
    b_en = 1; b_addr = 4'h0;
    step();
    idle();
    rst_n = 1'b0;
    model_clear();
    step();
    chk("rst drop v1b a", {31'b0, v1b}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst drop v1b b", {31'b0, v1b}, 32'd0);

    tbl[0]  = '{1,1,4'hF,4'h3,32'hDEADBEEF, 0,0,4'h0,4'h0,32'h0,
                1,32'h03030303, 0,32'h0, 0};
    tbl[1]  = '{0,0,4'h0,4'h0,32'h0, 1,0,4'h0,4'h3,32'h0,
                0,32'h03030303, 1,32'hDEADBEEF, 0};
    tbl[2]  = '{1,1,4'h5,4'h3,32'h11223344, 0,0,4'h0,4'h0,32'h0,
                1,32'hDEADBEEF, 0,32'hDEADBEEF, 0};
    tbl[3]  = '{1,0,4'h0,4'h3,32'h0, 0,0,4'h0,4'h0,32'h0,
                1,32'hDE22BE44, 0,32'hDEADBEEF, 0};
    tbl[4]  = '{1,1,4'hF,4'h5,32'hAAAAAAAA, 0,0,4'h0,4'h0,32'h0,
                1,32'h05050505, 0,32'hDEADBEEF, 0};
    tbl[5]  = '{1,1,4'hF,4'h5,32'h55555555, 0,0,4'h0,4'h0,32'h0,
                1,32'hAAAAAAAA, 0,32'hDEADBEEF, 0};
    tbl[6]  = '{1,1,4'h1,4'h7,32'h000000FF, 1,1,4'hF,4'h7,32'hFFFFFF00,
                1,32'h07070707, 1,32'h07070707, 1};
    tbl[7]  = '{0,0,4'h0,4'h0,32'h0, 0,0,4'h0,4'h0,32'h0,
                0,32'h07070707, 0,32'h07070707, 0};
    tbl[8]  = '{0,0,4'h0,4'h0,32'h0, 1,0,4'h0,4'h7,32'h0,
                0,32'h07070707, 1,32'hFFFFFFFF, 0};
    tbl[9]  = '{1,1,4'hF,4'h9,32'h12345678, 1,0,4'h0,4'h9,32'h0,
                1,32'h09090909, 1,32'h09090909, 0};
    tbl[10] = '{1,0,4'h0,4'h9,32'h0, 1,0,4'h0,4'h9,32'h0,
                1,32'h12345678, 1,32'h12345678, 0};
    tbl[11] = '{1,1,4'h0,4'h9,32'h0, 0,0,4'h0,4'h0,32'h0,
                1,32'h12345678, 0,32'h12345678, 0};
    tbl[12] = '{0,0,4'h0,4'h0,32'h0, 1,0,4'h0,4'h9,32'h0,
                0,32'h12345678, 1,32'h12345678, 0};
    tbl[13] = '{1,1,4'hF,4'h4,32'hCAFEF00D, 1,1,4'hF,4'h6,32'h0BADF00D,
                1,32'h04040404, 1,32'h06060606, 0};
    tbl[14] = '{1,0,4'h0,4'h4,32'h0, 1,0,4'h0,4'h6,32'h0,
                1,32'hCAFEF00D, 1,32'h0BADF00D, 0};

    for (int i = 0; i < 15; i++) begin
      a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_be = tbl[i].a_be;
      a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wd;
      b_en = tbl[i].b_en; b_we = tbl[i].b_we; b_be = tbl[i].b_be;
      b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wd;
      step();
      chk($sformatf("tbl%0d a_rvalid", i), {31'b0, v0a}, {31'b0, tbl[i].x_av});
      chk($sformatf("tbl%0d a_rdata", i), rd0a, tbl[i].x_ard);
      chk($sformatf("tbl%0d b_rvalid", i), {31'b0, v0b}, {31'b0, tbl[i].x_bv});
      chk($sformatf("tbl%0d b_rdata", i), rd0b, tbl[i].x_brd);
      chk($sformatf("tbl%0d coll", i), {31'b0, c0}, {31'b0, tbl[i].x_coll});
    end
    idle();
    step();

    // streaming reads through the 2-cycle instance
    preload();
    for (int k = 0; k < 18; k++) begin
      idle();
      if (k < 16) begin
        b_en = 1; b_addr = 4'(k);
      end
      step();
      if (k == 0) begin
        chk("stream first", {31'b0, v1b}, 32'd0);
      end else if (k <= 16) begin
        chk($sformatf("stream v%0d", k - 1), {31'b0, v1b}, 32'd1);
        chk($sformatf("stream d%0d", k - 1), rd1b, (k - 1) * 32'h01010101);
      end else begin
        chk("stream end", {31'b0, v1b}, 32'd0);
      end
    end
    idle();
    step();

    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset(2);
      a_en = ($urandom_range(0, 3) != 0);
      a_we = $urandom_range(0, 1) != 0;
      a_be = 4'($urandom_range(0, 15));
      a_addr = 4'($urandom_range(0, 15));
      a_wdata = $urandom;
      b_en = ($urandom_range(0, 3) != 0);
      b_we = $urandom_range(0, 1) != 0;
      b_be = 4'($urandom_range(0, 15));
      b_addr = ($urandom_range(0, 1) != 0) ? a_addr : 4'($urandom_range(0, 15));
      b_wdata = $urandom;
      step();
    end
    idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
